// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES ripple-carry chunks,
// one chunk per pipeline stage, with the carry registered between stages.
// Operand chunks not yet added ride along in skew registers. Finished sum
// chunks accumulate per stage, so the whole result leaves the last stage at once.
// Optional build macro: ADDSUB_SAT_EN. It saturates sum to the signed limit on overflow.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             c_out2,
    output logic             v,
    output logic             zero,
    output logic             neg
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_err
        $error("pipelined_addsub: WIDTH must be divisible by STAGES (STAGES >= 1)");
    end

    logic              advance;
    logic              in_fire;
    logic [WIDTH-1:0]  y_eff;
    logic              c_eff;
    logic [STAGES-1:0] vld_d, vld_q;
    logic [WIDTH-1:0]  raw_sum;

    // The whole pipe moves in lock-step. An empty output slot never blocks it.
    always_comb begin
        advance  = ~out_valid | out_ready;
        in_ready = advance;
        in_fire  = in_valid & advance;
    end

    // Subtract is x + ~y + ~c_in, so c_in acts as a borrow.
    always_comb begin
        y_eff = sub ? ~y : y;
        c_eff = sub ? ~c_in : c_in;
    end

    // The valid bits shift along with the data. Bubbles come in as 0.
    always_comb begin
        vld_d = vld_q;
        if (advance) begin
            vld_d[0] = in_fire;
            for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];
        end
    end

    // Valid shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int DONE = (k + 1) * CW;    // result bits known after this stage
        localparam int REM  = WIDTH - DONE;    // operand bits still to be added

        logic [CW-1:0]   a, b, s;
        logic            ci, co;
        logic [DONE-1:0] sum_d, sum_q;
        logic            co_d, co_q;

        if (k == 0) begin : g_src
            assign a  = x[CW-1:0];
            assign b  = y_eff[CW-1:0];
            assign ci = c_eff;
        end else begin : g_src
            assign a  = g_st[k-1].g_rest.x_rest_q[CW-1:0];
            assign b  = g_st[k-1].g_rest.y_rest_q[CW-1:0];
            assign ci = g_st[k-1].co_q;
        end

        // Ripple-add this stage's chunk using the carry from the previous stage
        always_comb begin
            {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
        end

        if (k == 0) begin : g_acc
            // The first chunk starts the result accumulator.
            always_comb begin
                sum_d = advance ? s : sum_q;
                co_d  = advance ? co : co_q;
            end
        end else begin : g_acc
            // Append this chunk above the chunks finished in earlier stages.
            always_comb begin
                sum_d = advance ? {s, g_st[k-1].sum_q} : sum_q;
                co_d  = advance ? co : co_q;
            end
        end

        // Stage result and carry registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                co_q  <= 1'b0;
            end else begin
                sum_q <= sum_d;
                co_q  <= co_d;
            end
        end

        if (REM > 0) begin : g_rest
            logic [REM-1:0] x_rest_d, x_rest_q, y_rest_d, y_rest_q;

            if (k == 0) begin : g_in
                // Skew: the upper operand chunks wait for later stages.
                always_comb begin
                    x_rest_d = advance ? x[WIDTH-1:CW] : x_rest_q;
                    y_rest_d = advance ? y_eff[WIDTH-1:CW] : y_rest_q;
                end
            end else begin : g_in
                // Skew: drop the chunk consumed here and pass the rest on.
                always_comb begin
                    x_rest_d = advance ? g_st[k-1].g_rest.x_rest_q[REM+CW-1:CW] : x_rest_q;
                    y_rest_d = advance ? g_st[k-1].g_rest.y_rest_q[REM+CW-1:CW] : y_rest_q;
                end
            end

            // Skew registers for the operand bits not yet added
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_rest_q <= '0;
                    y_rest_q <= '0;
                end else begin
                    x_rest_q <= x_rest_d;
                    y_rest_q <= y_rest_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic c2_d, c2_q;
`ifdef ADDSUB_SAT_EN
            logic xmsb_d, xmsb_q;
`endif
            // Carry into the MSB is recovered as s ^ a ^ b at that bit.
            always_comb begin
                c2_d = advance ? (s[CW-1] ^ a[CW-1] ^ b[CW-1]) : c2_q;
`ifdef ADDSUB_SAT_EN
                xmsb_d = advance ? a[CW-1] : xmsb_q;
`endif
            end

            // Flag-source registers of the final stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c2_q <= 1'b0;
`ifdef ADDSUB_SAT_EN
                    xmsb_q <= 1'b0;
`endif
                end else begin
                    c2_q <= c2_d;
`ifdef ADDSUB_SAT_EN
                    xmsb_q <= xmsb_d;
`endif
                end
            end
        end
    end

    // Outputs and flags are taken from the final registered stage.
    always_comb begin
        out_valid = vld_q[STAGES-1];
        raw_sum   = g_st[STAGES-1].sum_q;
        c_out     = g_st[STAGES-1].co_q;
        c_out2    = g_st[STAGES-1].g_last.c2_q;
        v         = c_out ^ c_out2;
        sum       = raw_sum;
`ifdef ADDSUB_SAT_EN
        if (v) sum = g_st[STAGES-1].g_last.xmsb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        // Gate zero with valid so the cleared (all-zero) slot does not report zero.
        zero      = out_valid & (sum == '0);
        neg       = sum[WIDTH-1];
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub (WIDTH=32, STAGES=4): directed cases, stalls,
// mid-flight reset and a random scoreboard run against a plain-arithmetic model.
module tb_pipelined_addsub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, sub, c_in;
    logic [WIDTH-1:0] x, y;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out, c_out2, v, zero, neg;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] s;
        logic        co, c2, v, z, n;
    } res_t;

    res_t exp_q[$];

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .c_in(c_in), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .c_out2(c_out2), .v(v), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic straight from the add/sub definitions
    function automatic res_t ref_op(input logic sb, input logic ci,
                                    input logic [31:0] xx, input logic [31:0] yy);
        res_t        r;
        logic [31:0] yb;
        logic        cb;
        logic [32:0] full;
        logic [31:0] low;
        yb   = sb ? ~yy : yy;
        cb   = sb ? ~ci : ci;
        full = {1'b0, xx} + {1'b0, yb} + {32'b0, cb};
        low  = {1'b0, xx[30:0]} + {1'b0, yb[30:0]} + {31'b0, cb};
        r.co = full[32];
        r.c2 = low[31];
        r.v  = r.co ^ r.c2;
        r.s  = full[31:0];
`ifdef ADDSUB_SAT_EN
        if (r.v) r.s = xx[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.z  = (r.s == 32'd0);
        r.n  = r.s[31];
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle
    task automatic drive(input logic iv, input logic sb, input logic ci,
                         input logic [31:0] xx, input logic [31:0] yy, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        sub       = sb;
        c_in      = ci;
        x         = xx;
        y         = yy;
        out_ready = ordy;
        #1;
    endtask

    // Issue one op into an idle pipe and wait (bounded) for its result
    task automatic run_single(input logic sb, input logic ci, input logic [31:0] xx,
                              input logic [31:0] yy, output res_t got, output int lat);
        got.s = '0; got.co = 0; got.c2 = 0; got.v = 0; got.z = 0; got.n = 0;
        lat = -1;
        drive(1'b1, sb, ci, xx, yy, 1'b1);
        for (int i = 1; i <= 12 && lat < 0; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
            if (out_valid) begin
                lat = i;
                got.s = sum; got.co = c_out; got.c2 = c_out2; got.v = v; got.z = zero; got.n = neg;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; sub = 0; c_in = 0; x = '0; y = '0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, sum, c_out, c_out2, v, zero, neg} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%0b sum=%h co=%0b c2=%0b v=%0b z=%0b n=%0b, want all 0",
                     out_valid, sum, c_out, c_out2, v, zero, neg);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
    endtask

    task automatic test_add_overflow();
        res_t g;
        int   lat;
        logic [31:0] want_s;
        logic        want_n;
`ifdef ADDSUB_SAT_EN
        want_s = 32'h7FFF_FFFF; want_n = 1'b0;
`else
        want_s = 32'h8000_0000; want_n = 1'b1;
`endif
        run_single(1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, g, lat);
        n_checks++;
        if (lat !== STAGES) begin
            n_fail++;
            $display("FAIL add_ovf_latency: got %0d, want %0d", lat, STAGES);
        end
        n_checks++;
        if ({g.s, g.v, g.co, g.c2, g.n, g.z} !== {want_s, 1'b1, 1'b0, 1'b1, want_n, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovf_result: got sum=%h v=%0b co=%0b c2=%0b n=%0b z=%0b, want sum=%h v=1 co=0 c2=1 n=%0b z=0",
                     g.s, g.v, g.co, g.c2, g.n, g.z, want_s, want_n);
        end
    endtask

    task automatic test_carry_ripple();
        res_t g;
        int   lat;
        run_single(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, g, lat);
        n_checks++;
        if ({g.s, g.z, g.co, g.c2, g.v} !== {32'd0, 1'b1, 1'b1, 1'b1, 1'b0} || lat !== STAGES) begin
            n_fail++;
            $display("FAIL carry_ripple: got sum=%h z=%0b co=%0b c2=%0b v=%0b lat=%0d, want sum=0 z=1 co=1 c2=1 v=0 lat=%0d",
                     g.s, g.z, g.co, g.c2, g.v, lat, STAGES);
        end
    endtask

    task automatic test_subtract();
        res_t g;
        int   lat;
        run_single(1'b1, 1'b0, 32'd0, 32'd1, g, lat);
        n_checks++;
        if ({g.s, g.co, g.n, g.v} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0} || lat !== STAGES) begin
            n_fail++;
            $display("FAIL sub_0_minus_1: got sum=%h co=%0b n=%0b v=%0b lat=%0d, want sum=ffffffff co=0 n=1 v=0 lat=%0d",
                     g.s, g.co, g.n, g.v, lat, STAGES);
        end
        run_single(1'b1, 1'b1, 32'd5, 32'd3, g, lat);
        n_checks++;
        if ({g.s, g.co} !== {32'd1, 1'b1} || lat !== STAGES) begin
            n_fail++;
            $display("FAIL sub_borrow_in: got sum=%h co=%0b lat=%0d, want sum=1 co=1 lat=%0d",
                     g.s, g.co, lat, STAGES);
        end
    endtask

    task automatic test_saturation();
        res_t g;
        int   lat;
        logic [31:0] want_s;
`ifdef ADDSUB_SAT_EN
        want_s = 32'h8000_0000;
`else
        want_s = 32'h7FFF_FFFF;
`endif
        run_single(1'b1, 1'b0, 32'h8000_0000, 32'd1, g, lat);
        n_checks++;
        if ({g.s, g.v} !== {want_s, 1'b1} || lat !== STAGES) begin
            n_fail++;
            $display("FAIL sub_ovf_sat: got sum=%h v=%0b lat=%0d, want sum=%h v=1 lat=%0d",
                     g.s, g.v, lat, want_s, STAGES);
        end
    endtask

    task automatic test_back_to_back();
        logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int          sent = 0, got = 0;
        logic        held = 0;
        logic [31:0] held_sum = '0;
        res_t        e;
        exp_q.delete();
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            drive(sent < 8, 1'b0, 1'b0, sent, 32'h10, pat[cyc % 7]);
            if (out_valid && !out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_stall_in_ready: cycle %0d got %0b, want 0", cyc, in_ready);
                end
            end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || sum !== held_sum) begin
                    n_fail++;
                    $display("FAIL b2b_hold_stable: cycle %0d got vld=%0b sum=%h, want vld=1 sum=%h",
                             cyc, out_valid, sum, held_sum);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(1'b0, 1'b0, sent, 32'h10));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_result: got sum=%h, want none", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e.s) begin
                        n_fail++;
                        $display("FAIL b2b_order: result %0d got sum=%h, want %h", got, sum, e.s);
                    end
                end
                got++;
            end
            held     = out_valid && !out_ready;
            held_sum = sum;
        end
        n_checks++;
        if (got != 8 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results with %0d outstanding, want 8 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        res_t        e;
        logic        sb, ci;
        logic [31:0] xx, yy;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            sb = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            xx = pick();
            yy = pick();
            drive(cyc < 380 && $urandom_range(0, 3) != 0, sb, ci, xx, yy,
                  cyc >= 380 || $urandom_range(0, 3) != 0);
            if (in_valid && in_ready) exp_q.push_back(ref_op(sb, ci, xx, yy));
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_result: cycle %0d got sum=%h, want none", cyc, sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, c_out, c_out2, v, zero, neg} !== {e.s, e.co, e.c2, e.v, e.z, e.n}) begin
                        n_fail++;
                        $display("FAIL rand_result: cycle %0d got sum=%h co=%0b c2=%0b v=%0b z=%0b n=%0b, want sum=%h co=%0b c2=%0b v=%0b z=%0b n=%0b",
                                 cyc, sum, c_out, c_out2, v, zero, neg, e.s, e.co, e.c2, e.v, e.z, e.n);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d results outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        res_t g;
        int   lat;
        int   seen = 0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'(i + 1), 32'd7, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 32'd8) begin
            n_fail++;
            $display("FAIL midrst_precond: got vld=%0b sum=%h, want vld=1 sum=00000008", out_valid, sum);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, sum, c_out, c_out2, v, zero, neg} !== 38'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got vld=%0b sum=%h co=%0b c2=%0b v=%0b z=%0b n=%0b, want all 0",
                     out_valid, sum, c_out, c_out2, v, zero, neg);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d stale valid cycles, want 0", seen);
        end
        run_single(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, g, lat);
        n_checks++;
        if (g.s !== 32'h2345_678A || lat !== STAGES) begin
            n_fail++;
            $display("FAIL midrst_new_op: got sum=%h lat=%0d, want sum=2345678a lat=%0d", g.s, lat, STAGES);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_carry_ripple();
        test_subtract();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined add/subtract unit. It is the next generation of the ALU's 32-bit ripple-carry adder.
- Splits a WIDTH-bit ripple add into STAGES equal chunks, one chunk per pipeline stage.
- Carry is registered between stages, so the clock period scales with WIDTH/STAGES rather than WIDTH.
- Adds a subtract mode, zero/negative flags and a valid/ready handshake.
- Sits between the ALU operand muxes and the result writeback mux.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth and number of carry chunks; >=1; WIDTH%STAGES!=0 is an elaboration error.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  unit can accept operands this cycle
sub  input  1  0 = add, 1 = subtract
c_in  input  1  carry-in (add) / borrow-in (sub)
x  input  WIDTH  operand A
y  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of bit WIDTH-1
c_out2  output  1  carry into bit WIDTH-1
v  output  1  signed overflow = c_out ^ c_out2
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all stage valid bits, data, skew and flag registers clear to 0. So out_valid=0, sum=0, c_out=c_out2=v=zero=neg=0. in_ready=1 while rst is low after reset.
- Arithmetic:
  - add: sum = x + y + c_in.
  - sub: sum = x + ~y + ~c_in, i.e. x - y - c_in, with c_in as borrow.
  - c_out in sub mode is the raw carry (1 = no borrow).
  - All results are modulo 2^WIDTH.
- Chunking: CW = WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds bits [k*CW +: CW] using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Unprocessed operand chunks travel through skew registers. Completed sum chunks are de-skewed so all of sum appears in the same cycle.
  - c_out2 is taken from the final stage's internal carry into the MSB.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational).
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - When advance=1, every stage shifts one step, and each stage valid bit takes the previous stage's valid (stage 0 takes in_valid & in_ready).
  - When advance=0, all stages hold and outputs stay stable.
- Latency: result is visible exactly STAGES cycles after acceptance when there is no stall. Throughput is 1 op/cycle. Results leave in issue order.
- Bubbles: in_valid=0 inserts a bubble. Bubbles do not stall upstream, and an empty output slot never blocks advance.
- Flags zero, neg and v are computed combinationally from the final registered stage and are valid only when out_valid=1.
- Reset mid-operation: all in-flight ops are discarded. out_valid drops immediately (async). No stale result emerges after rst deasserts.
- STAGES=1: single registered ripple adder, latency 1.
- Simultaneous in/out transfer while the pipeline is full: legal, no loss or duplication.

Optional Feature:
ADDSUB_SAT_EN.
- Defined: when the final-stage raw result has v=1, sum is replaced by the signed saturated value:
  - 0x7FF..F if x[MSB]==0 (operand A sign before inversion);
  - 0x800..0 otherwise.
  - c_out, c_out2 and v still report raw values. zero and neg follow the saturated sum.
- Undefined: sum wraps; no saturation logic is present.

Test Plan:
1. WIDTH=32, STAGES=4, add x=0x7FFFFFFF, y=1, c_in=0, out_ready=1 -> out_valid 4 cycles later, sum=0x80000000, v=1, c_out=0, c_out2=1, neg=1, zero=0.
2. Add x=0xFFFFFFFF, y=1, c_in=0 -> sum=0, zero=1, c_out=1, c_out2=1, v=0 (carry ripples through all 4 chunks).
3. Sub x=0, y=1, c_in=0 -> sum=0xFFFFFFFF, c_out=0, neg=1, v=0. Sub x=5, y=3, c_in=1 -> sum=1, c_out=1.
4. Issue 8 back-to-back ops with i=0..7 (x=i, y=0x10); out_ready pattern 1,0,0,1,0,1,1,... -> 8 results 0x10..0x17 in order, none lost or duplicated; sum stable while out_ready=0; in_ready=0 whenever out_valid=1 and out_ready=0.
5. Accept 3 ops, assert rst for 1 cycle mid-flight -> out_valid=0 immediately, all outputs 0; after release, no result appears until a new op is issued and STAGES cycles pass.
6. With ADDSUB_SAT_EN: case 1 -> sum=0x7FFFFFFF, v=1. Sub x=0x80000000, y=1 -> sum=0x80000000, v=1. Without the macro, the same inputs give 0x80000000 and 0x7FFFFFFF respectively.
